// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver for the UART link.
//
// Frame on RX_IN (idle high): start(0), DATA_LENGTH data bits LSB first,
// optional parity bit, one stop(1). Each bit lasts PRESCALE clocks. Each bit
// is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, and
// the 2-of-3 majority is taken as its value.
//
// Parameters:
//   DATA_LENGTH  data bits per frame (default 8)
//   PRESCALE     clocks per bit, even and >= 4 (default 8)
//
// Ports:
//   CLK         system clock, PRESCALE x bit rate
//   RST         synchronous active-high reset
//   RX_IN       serial line, idle high
//   PAR_EN      1 = frame has a parity bit (latched at frame start)
//   PAR_TYP     0 = even, 1 = odd parity (latched at frame start)
//   P_DATA      last correctly received data word
//   DATA_VALID  one-cycle strobe, P_DATA updated in the same cycle
//   PAR_ERR     one-cycle strobe, parity mismatch
//   STP_ERR     one-cycle strobe, stop bit sampled 0
//   Busy        high whenever the FSM is not in IDLE
//   dbg_state   current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Handshake: the outputs carry no back-pressure. DATA_VALID, PAR_ERR and
// STP_ERR are single-cycle strobes issued in the cycle after the last stop-bit
// clock. The consumer must take P_DATA in that cycle or keep its own copy.
//
// Optional feature, macro UART_RX_SYNC_EN: when defined, RX_IN passes through
// a 2-flop synchroniser (reset to 1) before the FSM, which delays all timing
// by two cycles. When undefined, RX_IN must already be synchronous to CLK.

module uart_rx #(
  parameter int DATA_LENGTH = 8,
  parameter int PRESCALE    = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic [DATA_LENGTH-1:0] P_DATA,
  output logic                   DATA_VALID,
  output logic                   PAR_ERR,
  output logic                   STP_ERR,
  output logic                   Busy,
  output logic [2:0]             dbg_state
);

  localparam int EW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] E_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] E_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], RX_IN};
  end

  // Reset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_q,    state_d;
  logic [EW-1:0]          edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]          bit_cnt_q,  bit_cnt_d;
  logic                   smp0_q,     smp0_d;
  logic                   smp1_q,     smp1_d;
  logic                   bit_q,      bit_d;
  logic [DATA_LENGTH-1:0] shift_q,    shift_d;
  logic                   par_en_q,   par_en_d;
  logic                   par_typ_q,  par_typ_d;
  logic                   par_bad_q,  par_bad_d;
  logic [DATA_LENGTH-1:0] p_data_q,   p_data_d;
  logic                   valid_q,    valid_d;
  logic                   par_err_q,  par_err_d;
  logic                   stp_err_q,  stp_err_d;

  logic maj;
  logic bit_now;
  logic end_of_bit;

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp0_d     = smp0_q;
    smp1_d     = smp1_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bad_d  = par_bad_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    // Majority uses the two stored samples plus the live third sample.
    maj        = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
    // With PRESCALE=4 the third sample point is also the last clock of the
    // bit, so the freshly computed majority must be used there directly.
    bit_now    = (edge_cnt_q == E_S2) ? maj : bit_q;
    end_of_bit = (edge_cnt_q == E_LAST);

    if (state_q != S_IDLE) begin
      edge_cnt_d = end_of_bit ? '0 : edge_cnt_q + EW'(1);
      if (edge_cnt_q == E_S0) smp0_d = rx_s;
      if (edge_cnt_q == E_S1) smp1_d = rx_s;
      if (edge_cnt_q == E_S2) bit_d  = maj;
    end

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        if (!rx_s) begin
          // This cycle already counts as edge 0 of the start bit.
          state_d    = S_START;
          edge_cnt_d = EW'(1);
          bit_cnt_d  = '0;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_bad_d  = 1'b0;
        end
      end

      S_START: begin
        if (edge_cnt_q == E_S2 && maj) begin
          // Start bit did not hold low: treat it as a glitch.
          state_d    = S_IDLE;
          edge_cnt_d = '0;
        end else if (end_of_bit) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (end_of_bit) begin
          shift_d[bit_cnt_q] = bit_now;
          if (bit_cnt_q == B_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      S_PARITY: begin
        if (end_of_bit) begin
          // Mismatch when the received bit differs from XOR(data) for even,
          // or from its inverse for odd.
          par_bad_d = bit_now ^ (^shift_q) ^ par_typ_q;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (end_of_bit) begin
          state_d   = S_IDLE;
          stp_err_d = ~bit_now;
          par_err_d = par_en_q & par_bad_q;
          valid_d   = bit_now & ~(par_en_q & par_bad_q);
          if (bit_now && !(par_en_q && par_bad_q)) p_data_d = shift_q;
        end
      end

      default: begin
        state_d    = S_IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      bit_q      <= 1'b1;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign Busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (DATA_LENGTH=8, PRESCALE=8).
// A frame-level model predicts, for each frame driven, the result cycle, the
// strobes, the new P_DATA and the Busy window; a per-cycle compare process
// checks the DUT against it. Literal checks pin the model's latencies/data.

module tb_uart_rx;

  localparam int DL = 8;
  localparam int P  = 8;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  // Expected event: {cycle[31:0], valid, par_err, stp_err, data[7:0]}
  localparam int EXP_W = 43;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DL-1:0] P_DATA;
  logic          DATA_VALID, PAR_ERR, STP_ERR, Busy;
  logic [2:0]    dbg_state;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx #(.DATA_LENGTH(DL), .PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .Busy(Busy), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               blo_q[$];
  int               bhi_q[$];
  logic [DL-1:0]    model_pdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Observations used only by the literal checks.
  int last_valid_cyc = -1, prev_valid_cyc = -1;
  int last_perr_cyc = -1, last_serr_cyc = -1;
  int valid_cnt = 0, perr_cnt = 0, serr_cnt = 0;

  logic             rst_prev = 1'b0;
  logic             cmp_en = 1'b0;
  logic [EXP_W-1:0] head;
  logic             ev_v, ev_p, ev_s, busy_exp;

  always @(negedge CLK) begin
    if (rst_prev) begin
      exp_q.delete();
      blo_q.delete();
      bhi_q.delete();
      model_pdata = '0;
      cmp_en      = 1'b1;
    end
    if (cmp_en) begin
      ev_v = 1'b0; ev_p = 1'b0; ev_s = 1'b0;
      if (exp_q.size() > 0 && int'(exp_q[0][42:11]) < cyc) begin
        head = exp_q.pop_front();
        check("stale_event", 64'(cyc), 64'(head[42:11]));
      end
      if (exp_q.size() > 0 && int'(exp_q[0][42:11]) == cyc) begin
        head = exp_q.pop_front();
        ev_v = head[10]; ev_p = head[9]; ev_s = head[8];
        if (ev_v) model_pdata = head[7:0];
      end
      while (bhi_q.size() > 0 && bhi_q[0] < cyc) begin
        void'(blo_q.pop_front());
        void'(bhi_q.pop_front());
      end
      busy_exp = (blo_q.size() > 0) && (blo_q[0] <= cyc) && (cyc <= bhi_q[0]);
      check("data_valid", 64'(DATA_VALID), 64'(ev_v));
      check("par_err",    64'(PAR_ERR),    64'(ev_p));
      check("stp_err",    64'(STP_ERR),    64'(ev_s));
      check("p_data",     64'(P_DATA),     64'(model_pdata));
      if (Busy !== busy_exp)
        $display("  busy detail: state=%0d", dbg_state);
      check("busy",       64'(Busy),       64'(busy_exp));
    end
    if (DATA_VALID === 1'b1) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      valid_cnt++;
    end
    if (PAR_ERR === 1'b1) begin last_perr_cyc = cyc; perr_cnt++; end
    if (STP_ERR === 1'b1) begin last_serr_cyc = cyc; serr_cnt++; end
    rst_prev = RST;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge; one loop pass = one cycle)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one frame. n0 returns the cycle at which the receiver sees the
  // start bit. spike_off/rst_off are frame-relative cycles (-1 = none).
  task automatic send_frame(input logic [DL-1:0] d, input logic pe,
                            input logic typ, input logic par_bit,
                            input logic stop_bit, input int spike_off,
                            input int rst_off, output int n0);
    int   nb;
    logic b;
    logic perr, serr;
    nb   = pe ? DL + 3 : DL + 2;
    n0   = cyc + LAT;
    serr = ~stop_bit;
    perr = pe & (par_bit != ((^d) ^ typ));
    exp_q.push_back({32'(n0 + nb * P), ~serr & ~perr, perr, serr, d});
    blo_q.push_back(n0 + 1);
    bhi_q.push_back(n0 + nb * P - 1);
    PAR_EN  = pe;
    PAR_TYP = typ;
    for (int k = 0; k < nb * P; k++) begin
      int j;
      j = k / P;
      if (j == 0)                 b = 1'b0;
      else if (j <= DL)           b = d[j-1];
      else if (pe && j == DL + 1) b = par_bit;
      else                        b = stop_bit;
      if (k == spike_off) b = ~b;
      if (rst_off >= 0 && k > rst_off) b = 1'b1;
      RX_IN = b;
      RST   = (k == rst_off);
      if (k == 3 * P) begin
        PAR_EN  = ~pe;
        PAR_TYP = ~typ;
      end
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
  endtask

  // Start bit held low for only two cycles: rejected at the third sample.
  task automatic send_glitch(output int n0);
    n0 = cyc + LAT;
    blo_q.push_back(n0 + 1);
    bhi_q.push_back(n0 + P / 2 + 1);
    RX_IN = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    idle(12);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int n0, vc, pc;

  initial begin
    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset_p_data", 64'(P_DATA), 64'h0);
    check("reset_busy",   64'(Busy),   64'h0);
    idle(5);

    // Plain 8N1 frame.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, n0);
    idle(4);
    check("t55_valid_cycle", 64'(last_valid_cyc - n0), 64'd80);
    check("t55_p_data",      64'(P_DATA), 64'h55);

    // Even parity, correct bit (0xA3 has four ones -> 0).
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, n0);
    idle(4);
    check("tA3e_valid_cycle", 64'(last_valid_cyc - n0), 64'd88);
    check("tA3e_p_data",      64'(P_DATA), 64'hA3);

    // Odd parity, correct bit 1.
    vc = valid_cnt;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, n0);
    idle(4);
    check("tA3o_valid_cnt", 64'(valid_cnt - vc), 64'd1);
    check("tA3o_valid_cycle", 64'(last_valid_cyc - n0), 64'd88);

    // Even parity, wrong bit -> PAR_ERR only.
    vc = valid_cnt;
    send_frame(8'h5C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, n0);
    idle(4);
    check("tperr_cycle",   64'(last_perr_cyc - n0), 64'd88);
    check("tperr_novalid", 64'(valid_cnt - vc), 64'd0);
    check("tperr_p_data",  64'(P_DATA), 64'hA3);

    // Stop bit 0 on 0x3C.
    vc = valid_cnt;
    pc = perr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, n0);
    idle(4);
    check("tserr_cycle",   64'(last_serr_cyc - n0), 64'd80);
    check("tserr_novalid", 64'(valid_cnt - vc), 64'd0);
    check("tserr_noperr",  64'(perr_cnt - pc), 64'd0);
    check("tserr_p_data",  64'(P_DATA), 64'hA3);

    // Glitch, then a good 0x0F frame.
    vc = valid_cnt;
    send_glitch(n0);
    check("tglitch_busy",    64'(Busy), 64'h0);
    check("tglitch_novalid", 64'(valid_cnt - vc), 64'd0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, n0);
    idle(4);
    check("t0F_p_data", 64'(P_DATA), 64'h0F);

    // One-cycle spike at the middle sample of data bit 3.
    send_frame(8'hB6, 1'b0, 1'b0, 1'b0, 1'b1, 4 * P + P / 2, -1, n0);
    idle(4);
    check("tspike_p_data", 64'(P_DATA), 64'hB6);

    // Back-to-back frames with no idle gap.
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, n0);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, n0);
    idle(4);
    check("tb2b_gap",    64'(last_valid_cyc - prev_valid_cyc), 64'd80);
    check("tb2b_p_data", 64'(P_DATA), 64'h34);

    // Reset in the middle of a frame, then a fresh frame.
    vc = valid_cnt;
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, -1, 40, n0);
    check("trst_p_data",  64'(P_DATA), 64'h0);
    check("trst_busy",    64'(Busy), 64'h0);
    check("trst_novalid", 64'(valid_cnt - vc), 64'd0);
    idle(4);
    send_frame(8'hC4, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, n0);
    idle(6);
    check("tC4_p_data",    64'(P_DATA), 64'hC4);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
